// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search engine.
//   state_e      : 2-bit FSM encoding (IDLE=0, TRY=1, DONE=2)
//   F_*          : bit positions of the comparator flag vector {greater, equal, smaller}
//   flags_ok()   : true when exactly one comparator flag is set
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRY  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int F_SMALLER = 0;
  localparam int F_EQUAL   = 1;
  localparam int F_GREATER = 2;

  function automatic logic flags_ok(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

endpackage

// File: rtl/sar_search_nbit.sv
// sar_search_nbit: successive-approximation search driving an external comparator.
// Proposes guesses MSB first, one bit per TRY cycle, and reads smaller/equal/greater
// (guess vs target) back combinationally in the same cycle.
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   start                begin a search (sampled only in IDLE)
//   smaller/equal/greater comparator flags for the current guess
//   guess [N-1:0]        trial value to comparator input a
//   busy                 high while searching (TRY)
//   done                 one-cycle pulse, result valid
//   result [N-1:0]       found value, held until the next accepted start
//   flag_err             sticky: flags were not one-hot during a TRY cycle
module sar_search_nbit
  import sar_pkg::*;
#(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         smaller,
  input  logic         equal,
  input  logic         greater,
  output logic [N-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         flag_err
);

  localparam int BW = $clog2(N);
  localparam logic [N-1:0]  ONE    = N'(1);
  localparam logic [BW-1:0] IDX_HI = BW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  guess_q, guess_d;
  logic [N-1:0]  result_q, result_d;
  logic          err_q, err_d;

  logic [2:0]    flags;
  logic          ok;
  logic [N-1:0]  acc_nxt;
  logic [BW-1:0] bit_m1;

  assign flags = {greater, equal, smaller};
  assign ok    = flags_ok(flags);
  // Bad flags fall through as "greater": the trial bit is dropped.
  assign acc_nxt = (ok && flags[F_SMALLER]) ? guess_q : acc_q;
  assign bit_m1  = bit_q - BW'(1);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    guess_d  = guess_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRY;
          acc_d   = '0;
          bit_d   = IDX_HI;
          guess_d = ONE << IDX_HI;
          err_d   = 1'b0;
        end
      end
      S_TRY: begin
        err_d = err_q | ~ok;
        if (ok && flags[F_EQUAL]) begin
          result_d = guess_q;
          state_d  = S_DONE;
        end else if (bit_q == '0) begin
          acc_d    = acc_nxt;
          result_d = acc_nxt;
          state_d  = S_DONE;
        end else begin
          acc_d   = acc_nxt;
          bit_d   = bit_m1;
          guess_d = acc_nxt | (ONE << bit_m1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      bit_q    <= IDX_HI;
      guess_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign guess    = guess_q;
  assign busy     = (state_q == S_TRY);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign flag_err = err_q;

endmodule

// File: tb/tb_sar_search_nbit.sv
// Bench for sar_search_nbit (N=12) with a behavioural comparator on the guess/target pair.
module tb_sar_search_nbit;
  localparam int N = 12;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] target = '0;
  logic         inj = 1'b0;
  logic         smaller, equal, greater;
  logic [N-1:0] guess, result;
  logic         busy, done, flag_err;

  int n_chk = 0;
  int n_fail = 0;
  logic [N-1:0] prev_res = '0;

  always #5 clk = ~clk;

  // Comparator; inj forces an illegal smaller+greater pair.
  assign smaller = inj ? 1'b1 : (guess < target);
  assign greater = inj ? 1'b1 : (guess > target);
  assign equal   = inj ? 1'b0 : (guess == target);

  sar_search_nbit #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .smaller(smaller), .equal(equal), .greater(greater),
    .guess(guess), .busy(busy), .done(done),
    .result(result), .flag_err(flag_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full search. inj_step: TRY step (0-based) with bad flags, -1 none.
  // repulse: cycle number in which start is pulsed again, -1 none.
  task automatic search(input logic [N-1:0] tgt, input int inj_step, input int repulse);
    logic [N-1:0] acc, g, exp_res;
    logic [N-1:0] exp_g[$];
    int lat, nbusy;
    bit fin;
    acc = '0; lat = N; exp_res = '0; fin = 0;
    for (int i = N - 1; i >= 0; i--) begin
      g = acc | N'(1 << i);
      exp_g.push_back(g);
      if ((N - 1 - i) == inj_step) continue;
      if (g == tgt) begin exp_res = g; lat = N - i; fin = 1; break; end
      if (g < tgt) acc = g;
    end
    if (!fin) exp_res = acc;

    target = tgt;
    @(negedge clk) start = 1'b1;
    nbusy = 0; fin = 0;
    for (int cyc = 1; cyc <= N + 4; cyc++) begin
      @(negedge clk);
      start = (cyc == repulse);
      inj = (cyc - 1 == inj_step);
      if (cyc == 1) chk("err_clr_on_start", flag_err, 0);
      if (busy) begin
        nbusy++;
        if (cyc - 1 < exp_g.size()) chk("guess_seq", guess, exp_g[cyc-1]);
        chk("result_held", result, prev_res);
      end
      if (done) begin
        inj = 1'b0;
        chk("done_latency", cyc, lat + 1);
        chk("busy_cycles", nbusy, lat);
        chk("result", result, exp_res);
        chk("flag_err", flag_err, (inj_step >= 0 && inj_step < lat));
        prev_res = exp_res;
        fin = 1;
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse_1cyc", done, 0);
        chk("idle_not_busy", busy, 0);
        break;
      end
    end
    inj = 1'b0;
    start = 1'b0;
    if (!fin) chk("timeout_no_done", 0, 1);
  endtask

  initial begin
    #12;
    chk("rst_guess", guess, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", flag_err, 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", busy, 0);

    search(12'd0, -1, -1);
    search(12'd2048, -1, -1);
    search(12'd4095, -1, -1);
    search(12'd1234, -1, -1);
    search(12'd1, -1, -1);
    for (int k = 0; k < 20; k++) search(N'($urandom_range(0, (1 << N) - 1)), -1, -1);

    // start re-pulsed mid-search is ignored
    search(12'd1234, -1, 4);
    search(12'd0, -1, 4);

    // bad flags on one TRY cycle, then a clean search clears flag_err
    search(12'd3000, 3, -1);
    search(12'd2048, 0, -1);
    search(12'd77, -1, -1);

    // reset in cycle 5 of a search
    target = 12'd1500;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_guess", guess, 0);
    chk("midrst_result", result, 0);
    chk("midrst_err", flag_err, 0);
    prev_res = '0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    reset_n = 1'b1;
    search(12'd1500, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
